// File: rtl/lt24_write_controller_pkg.sv
// Shared definitions for the LT24 write controller: FSM state encoding and
// the levels the panel bus rests at when no write cycle is running.
package lt24_write_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_LOW  = 2'd1,
    ST_WR_HIGH = 2'd2
  } lt24_state_e;

  localparam logic BUS_CS_N_IDLE = 1'b1;
  localparam logic BUS_WR_N_IDLE = 1'b1;
  localparam logic BUS_RD_N_IDLE = 1'b1;
  localparam logic BUS_RS_IDLE   = 1'b0;

endpackage

// File: rtl/lt24_cmd_fifo.sv
// Small synchronous FIFO holding {is_data, word} entries for the LT24 writer.
// Read data is the head entry, valid whenever the FIFO is not empty.
module lt24_cmd_fifo #(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH      = 17
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      push_data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      pop_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign full_o     = (count_q == CNT_FULL);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign push_ok_s  = push_i && !full_o;
  assign pop_ok_s   = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lt24_write_controller.sv
// Turns queued command/data words into LT24 8080-style write cycles; the bus
// FSM steps only on the enable strobe while upstream pushes at full clock rate.
module lt24_write_controller #(
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int DATA_WIDTH      = 16
) (
  input  logic                  input_clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_is_data,
  input  logic [DATA_WIDTH-1:0] in_word,
  output logic                  busy,
  output logic                  lcd_cs_n,
  output logic                  lcd_rs,
  output logic                  lcd_wr_n,
  output logic                  lcd_rd_n,
  output logic [DATA_WIDTH-1:0] lcd_d
);
  import lt24_write_controller_pkg::*;

  localparam int EW = DATA_WIDTH + 1;
  localparam int CW = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  lt24_state_e           state_q;
  logic                  cs_n_q;
  logic                  wr_n_q;
  logic                  rs_q;
  logic [DATA_WIDTH-1:0] d_q;
  logic                  busy_q;

  logic [EW-1:0]         head_s;
  logic [CW-1:0]         fifo_count_s;
  logic [CW-1:0]         fifo_count_d;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  active_d;

  assign in_ready = !fifo_full_s;
  assign push_s   = in_valid && in_ready;
  assign busy     = busy_q;
  assign lcd_cs_n = cs_n_q;
  assign lcd_wr_n = wr_n_q;
  assign lcd_rs   = rs_q;
  assign lcd_d    = d_q;
  assign lcd_rd_n = BUS_RD_N_IDLE;

  lt24_cmd_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (EW)
  ) u_fifo (
    .clk_i       (input_clock),
    .rst_i       (reset),
    .push_i      (push_s),
    .push_data_i ({in_is_data, in_word}),
    .pop_i       (pop_s),
    .pop_data_o  (head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_s)
  );

  // A word leaves the FIFO only on an enable that starts a WR# low phase.
  always_comb begin
    pop_s = 1'b0;
    if (enable && !fifo_empty_s && (state_q == ST_IDLE || state_q == ST_WR_HIGH)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Next-cycle occupancy and bus activity, so busy can be a plain register.
  always_comb begin
    fifo_count_d = fifo_count_s;
    active_d     = (state_q != ST_IDLE);
    case ({push_s, pop_s})
      2'b10:   fifo_count_d = fifo_count_s + CNT_ONE;
      2'b01:   fifo_count_d = fifo_count_s - CNT_ONE;
      default: fifo_count_d = fifo_count_s;
    endcase
    if (enable) begin
      active_d = (state_q == ST_WR_LOW) || pop_s;
    end else begin
      active_d = (state_q != ST_IDLE);
    end
  end

  always_ff @(posedge input_clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cs_n_q  <= BUS_CS_N_IDLE;
      wr_n_q  <= BUS_WR_N_IDLE;
      rs_q    <= BUS_RS_IDLE;
      d_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= active_d || (fifo_count_d != '0);
      if (enable) begin
        case (state_q)
          ST_IDLE: begin
            if (!fifo_empty_s) begin
              d_q     <= head_s[DATA_WIDTH-1:0];
              rs_q    <= head_s[DATA_WIDTH];
              cs_n_q  <= 1'b0;
              wr_n_q  <= 1'b0;
              state_q <= ST_WR_LOW;
            end
          end
          ST_WR_LOW: begin
            wr_n_q  <= 1'b1;
            state_q <= ST_WR_HIGH;
          end
          ST_WR_HIGH: begin
            // Back-to-back words keep CS# low; d/rs only move as WR# falls.
            if (!fifo_empty_s) begin
              d_q     <= head_s[DATA_WIDTH-1:0];
              rs_q    <= head_s[DATA_WIDTH];
              wr_n_q  <= 1'b0;
              state_q <= ST_WR_LOW;
            end else begin
              cs_n_q  <= BUS_CS_N_IDLE;
              state_q <= ST_IDLE;
            end
          end
          default: begin
            cs_n_q  <= BUS_CS_N_IDLE;
            wr_n_q  <= BUS_WR_N_IDLE;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
